// File: rtl/harvos_dmem_ram_pkg.sv
// harvos_dmem_ram_pkg
//   Shared types and helpers for the harvos data RAM slave.
//   - harvos_dmem_flt_e : fault cause reported on the D-port fault log
//   - HARVOS_DMEM_BASE  : default byte base address of the data RAM
//   - harvos_be_legal() : byte-enable legality (byte, aligned half, full word)
package harvos_dmem_ram_pkg;

  typedef enum logic [1:0] {
    FLT_NONE   = 2'd0,
    FLT_RANGE  = 2'd1,
    FLT_ALIGN  = 2'd2,
    FLT_PARITY = 2'd3
  } harvos_dmem_flt_e;

  localparam logic [31:0] HARVOS_DMEM_BASE = 32'h2000_0000;

  // Single bytes, aligned halfwords and the full word are the only shapes
  // the core issues; anything else (including no lanes) is a fault.
  function automatic logic harvos_be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/harvos_dmem_lane.sv
// harvos_dmem_lane
//   One byte lane of the data RAM: WORDS x 8 bits, plus one even-parity bit
//   per entry when DMEM_PARITY_EN is defined. Read data is registered and
//   only updates on i_re, so it holds between reads.
// Ports
//   clk        clock
//   i_we       write strobe for this lane
//   i_re       read strobe (loads o_rbyte)
//   i_idx      word index
//   i_wbyte    write byte
//   i_par_flip invert the stored parity bit (DMEM_PARITY_EN only)
//   o_rbyte    registered read byte
//   o_perr     parity mismatch on the registered read (DMEM_PARITY_EN only)
module harvos_dmem_lane #(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  logic [7:0]    i_wbyte,
`ifdef DMEM_PARITY_EN
  input  logic          i_par_flip,
  output logic          o_perr,
`endif
  output logic [7:0]    o_rbyte
);

  logic [7:0] r_mem [WORDS];
  logic [7:0] r_rbyte;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wbyte;
    if (i_re) r_rbyte      <= r_mem[i_idx];
  end

  assign o_rbyte = r_rbyte;

`ifdef DMEM_PARITY_EN
  logic r_par [WORDS];
  logic r_rpar;

  always_ff @(posedge clk) begin
    if (i_we) r_par[i_idx] <= (^i_wbyte) ^ i_par_flip;
    if (i_re) r_rpar       <= r_par[i_idx];
  end

  assign o_perr = r_rpar ^ (^r_rbyte);
`endif

endmodule

// File: rtl/harvos_dmem_ram.sv
// harvos_dmem_ram
//   Single-port data RAM slave on the core D-port, one-cycle response for
//   every accepted request. Faults: out-of-range address, illegal byte
//   enable and (with DMEM_PARITY_EN defined) read parity error. A sticky
//   fault log records count, last faulting address and cause.
// Ports
//   clk, rst_n            clock, async active-low reset
//   dmem_req_i/we_i/be_i/addr_i/wdata_i   D-port request
//   dmem_rvalid_o/rdata_o/fault_o         D-port response
//   flt_clr_i             clear the fault log (a same-cycle fault still logs)
//   flt_cnt_o             faulted request count, saturating
//   flt_addr_o            address of most recent fault
//   flt_cause_o           cause of most recent fault
//   par_inject_i          per-lane parity flip on write (DMEM_PARITY_EN)
// Config macro: DMEM_PARITY_EN
module harvos_dmem_ram
  import harvos_dmem_ram_pkg::*;
#(
  parameter int          WORDS     = 16384,
  parameter logic [31:0] BASE_ADDR = HARVOS_DMEM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_fault_o,
  input  logic        flt_clr_i,
  output logic [15:0] flt_cnt_o,
  output logic [31:0] flt_addr_o,
  output logic [1:0]  flt_cause_o,
  input  logic [3:0]  par_inject_i
);

  localparam int AW = $clog2(WORDS);

  // ---------------- decode (request cycle) ----------------
  logic [29:0]      w_off;
  logic             w_hit;
  harvos_dmem_flt_e w_cause;
  logic             w_req_flt;
  logic             w_we;
  logic             w_re;
  logic [3:0]       w_lane_we;
  logic [31:0]      w_rword;
  logic             w_par_flt;

  // Subtraction wraps for addresses below the base, so one compare
  // covers both ends of the window.
  assign w_off = dmem_addr_i[31:2] - BASE_ADDR[31:2];
  assign w_hit = (w_off < 30'(WORDS));

  always_comb begin
    w_cause = FLT_NONE;
    if (!w_hit)                          w_cause = FLT_RANGE;
    else if (!harvos_be_legal(dmem_be_i)) w_cause = FLT_ALIGN;
  end

  assign w_req_flt = dmem_req_i && (w_cause != FLT_NONE);
  assign w_we      = dmem_req_i &&  dmem_we_i && !w_req_flt;
  assign w_re      = dmem_req_i && !dmem_we_i && !w_req_flt;
  assign w_lane_we = {4{w_we}} & dmem_be_i;

  // ---------------- byte lanes ----------------
`ifdef DMEM_PARITY_EN
  logic [3:0] w_perr;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_lane
    harvos_dmem_lane #(.WORDS(WORDS), .AW(AW)) u_lane (
      .clk        (clk),
      .i_we       (w_lane_we[g]),
      .i_re       (w_re),
      .i_idx      (w_off[AW-1:0]),
      .i_wbyte    (dmem_wdata_i[8*g +: 8]),
`ifdef DMEM_PARITY_EN
      .i_par_flip (par_inject_i[g]),
      .o_perr     (w_perr[g]),
`endif
      .o_rbyte    (w_rword[8*g +: 8])
    );
  end

  // ---------------- response register ----------------
  logic r_rvalid;
  logic r_flt_req;
  logic r_rd_ok;   // lanes hold good read data that may be shown

`ifdef DMEM_PARITY_EN
  logic        r_rd_pend;
  logic [31:0] r_addr;

  // Parity is only known once the stored bits are read out, so a parity
  // fault shows up in the response cycle and is logged at its end.
  assign w_par_flt = r_rd_pend && (|w_perr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_rd_pend <= w_re;
      if (dmem_req_i) r_addr <= dmem_addr_i;
    end
  end

  logic w_unused;
  assign w_unused = ^w_off[29:AW];
`else
  assign w_par_flt = 1'b0;

  logic w_unused;
  assign w_unused = ^{w_off[29:AW], par_inject_i};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid  <= 1'b0;
      r_flt_req <= 1'b0;
      r_rd_ok   <= 1'b0;
    end else begin
      r_rvalid  <= dmem_req_i;
      r_flt_req <= w_req_flt;
      if (w_par_flt) r_rd_ok <= 1'b0;
      // A faulted request zeroes rdata; a good write leaves it alone.
      if (w_req_flt)  r_rd_ok <= 1'b0;
      else if (w_re)  r_rd_ok <= 1'b1;
    end
  end

  assign dmem_rvalid_o = r_rvalid;
  assign dmem_fault_o  = r_flt_req | w_par_flt;
  assign dmem_rdata_o  = (r_rd_ok && !w_par_flt) ? w_rword : 32'h0;

  // ---------------- fault log ----------------
  logic [15:0] r_cnt;
  logic [31:0] r_faddr;
  logic [1:0]  r_fcause;
  logic [15:0] w_cnt_base;
  logic [1:0]  w_nflt;
  logic [16:0] w_cnt_sum;

  // A request fault and the previous read's parity fault can land in the
  // same cycle; both count, the newer request fault owns addr/cause.
  assign w_cnt_base = flt_clr_i ? 16'h0 : r_cnt;
  assign w_nflt     = {1'b0, w_req_flt} + {1'b0, w_par_flt};
  assign w_cnt_sum  = {1'b0, w_cnt_base} + {15'h0, w_nflt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_faddr  <= '0;
      r_fcause <= FLT_NONE;
    end else begin
      r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      if (w_req_flt) begin
        r_faddr  <= dmem_addr_i;
        r_fcause <= w_cause;
      end
`ifdef DMEM_PARITY_EN
      else if (w_par_flt) begin
        r_faddr  <= r_addr;
        r_fcause <= FLT_PARITY;
      end
`endif
      else if (flt_clr_i) begin
        r_faddr  <= '0;
        r_fcause <= FLT_NONE;
      end
    end
  end

  assign flt_cnt_o   = r_cnt;
  assign flt_addr_o  = r_faddr;
  assign flt_cause_o = r_fcause;

endmodule

// File: tb/tb_harvos_dmem_ram.sv
// Directed bench for harvos_dmem_ram: table of request/expected-response
// records plus hand sequences for reset and back-to-back ordering.
module tb_harvos_dmem_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, clr;
  logic [3:0]  be, inj;
  logic [31:0] addr, wdata;
  logic        rvalid, fault;
  logic [31:0] rdata, faddr;
  logic [15:0] cnt;
  logic [1:0]  cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  harvos_dmem_ram dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_req_i    (req),
    .dmem_we_i     (we),
    .dmem_be_i     (be),
    .dmem_addr_i   (addr),
    .dmem_wdata_i  (wdata),
    .dmem_rvalid_o (rvalid),
    .dmem_rdata_o  (rdata),
    .dmem_fault_o  (fault),
    .flt_clr_i     (clr),
    .flt_cnt_o     (cnt),
    .flt_addr_o    (faddr),
    .flt_cause_o   (cause),
    .par_inject_i  (inj)
  );

  localparam logic [1:0] C_NONE = 2'd0, C_RANGE = 2'd1, C_ALIGN = 2'd2, C_PAR = 2'd3;

`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic        req, we, clr;
    logic [3:0]  be, inj;
    logic [31:0] addr, wdata;
    logic        e_rv, e_flt;
    logic [31:0] e_rdata;
    logic [15:0] e_cnt;
    logic [1:0]  e_cause;
    logic [31:0] e_faddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [3:0] pi,
                     input logic erv, input logic ef, input logic [31:0] erd,
                     input logic [15:0] ec, input logic [1:0] eca,
                     input logic [31:0] efa);
    vec_t v;
    v.req = r; v.we = w; v.be = b; v.addr = a; v.wdata = d; v.clr = c; v.inj = pi;
    v.e_rv = erv; v.e_flt = ef; v.e_rdata = erd; v.e_cnt = ec;
    v.e_cause = eca; v.e_faddr = efa;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic c, input logic [3:0] pi);
    req = r; we = w; be = b; addr = a; wdata = d; clr = c; inj = pi;
  endtask

  initial begin
    drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_fault",  {31'h0, fault},  32'h0);
    chk("rst_rdata",  rdata, 32'h0);
    chk("rst_cnt",    {16'h0, cnt}, 32'h0);
    chk("rst_faddr",  faddr, 32'h0);
    chk("rst_cause",  {30'h0, cause}, {30'h0, C_NONE});
    rst_n = 1'b1;

    //   req we be     addr          wdata         clr inj    rv flt rdata         cnt cause    faddr
    add(1, 1, 4'hF, 32'h2000_0000, 32'hDEAD_BEEF, 0, 4'h0,  1, 0, 32'h0,         0, C_NONE,  32'h0);
    add(1, 0, 4'hF, 32'h2000_0000, 32'h0,         0, 4'h0,  1, 0, 32'hDEAD_BEEF, 0, C_NONE,  32'h0);
    add(1, 1, 4'hF, 32'h2000_0004, 32'h1122_3344, 0, 4'h0,  1, 0, 32'hDEAD_BEEF, 0, C_NONE,  32'h0);
    add(1, 1, 4'h1, 32'h2000_0004, 32'h0000_00AA, 0, 4'h0,  1, 0, 32'hDEAD_BEEF, 0, C_NONE,  32'h0);
    add(1, 0, 4'hF, 32'h2000_0004, 32'h0,         0, 4'h0,  1, 0, 32'h1122_33AA, 0, C_NONE,  32'h0);
    add(1, 1, 4'hC, 32'h2000_0004, 32'h5566_0000, 0, 4'h0,  1, 0, 32'h1122_33AA, 0, C_NONE,  32'h0);
    add(1, 0, 4'hF, 32'h2000_0004, 32'h0,         0, 4'h0,  1, 0, 32'h5566_33AA, 0, C_NONE,  32'h0);
    add(0, 0, 4'h0, 32'h0,         32'h0,         0, 4'h0,  0, 0, 32'h5566_33AA, 0, C_NONE,  32'h0);
    add(1, 0, 4'hF, 32'h2001_0000, 32'h0,         0, 4'h0,  1, 1, 32'h0,         1, C_RANGE, 32'h2001_0000);
    add(0, 0, 4'h0, 32'h0,         32'h0,         0, 4'h0,  0, 0, 32'h0,         1, C_RANGE, 32'h2001_0000);
    add(1, 1, 4'hF, 32'h2000_0008, 32'h1234_5678, 0, 4'h0,  1, 0, 32'h0,         1, C_RANGE, 32'h2001_0000);
    add(1, 1, 4'h5, 32'h2000_0008, 32'hFFFF_FFFF, 0, 4'h0,  1, 1, 32'h0,         2, C_ALIGN, 32'h2000_0008);
    add(1, 0, 4'hF, 32'h2000_0008, 32'h0,         0, 4'h0,  1, 0, 32'h1234_5678, 2, C_ALIGN, 32'h2000_0008);
    add(1, 1, 4'h5, 32'h2000_0008, 32'hFFFF_FFFF, 1, 4'h0,  1, 1, 32'h0,         1, C_ALIGN, 32'h2000_0008);
    add(0, 0, 4'h0, 32'h0,         32'h0,         1, 4'h0,  0, 0, 32'h0,         0, C_NONE,  32'h0);
    add(1, 0, 4'hF, 32'h1FFF_FFFC, 32'h0,         0, 4'h0,  1, 1, 32'h0,         1, C_RANGE, 32'h1FFF_FFFC);
    add(1, 1, 4'hF, 32'h2000_FFFC, 32'hA5A5_A5A5, 0, 4'h0,  1, 0, 32'h0,         1, C_RANGE, 32'h1FFF_FFFC);
    add(1, 0, 4'hF, 32'h2000_FFFC, 32'h0,         0, 4'h0,  1, 0, 32'hA5A5_A5A5, 1, C_RANGE, 32'h1FFF_FFFC);
    add(1, 1, 4'h0, 32'h2000_0014, 32'h0,         0, 4'h0,  1, 1, 32'h0,         2, C_ALIGN, 32'h2000_0014);
    add(1, 0, 4'hF, 32'h2000_0003, 32'h0,         0, 4'h0,  1, 0, 32'hDEAD_BEEF, 2, C_ALIGN, 32'h2000_0014);
    add(1, 1, 4'hF, 32'h2000_0010, 32'hCAFE_F00D, 0, 4'h2,  1, 0, 32'hDEAD_BEEF, 2, C_ALIGN, 32'h2000_0014);
    // parity fault is logged at the end of its response cycle
    add(1, 0, 4'hF, 32'h2000_0010, 32'h0,         0, 4'h0,  1, PAR, PAR ? 32'h0 : 32'hCAFE_F00D,
        2, C_ALIGN, 32'h2000_0014);
    add(0, 0, 4'h0, 32'h0,         32'h0,         0, 4'h0,  0, 0, PAR ? 32'h0 : 32'hCAFE_F00D,
        PAR ? 16'd3 : 16'd2, PAR ? C_PAR : C_ALIGN, PAR ? 32'h2000_0010 : 32'h2000_0014);

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].clr, tbl[i].inj);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rvalid", i), {31'h0, rvalid}, {31'h0, tbl[i].e_rv});
      chk($sformatf("v%0d_fault", i),  {31'h0, fault},  {31'h0, tbl[i].e_flt});
      chk($sformatf("v%0d_rdata", i),  rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_cnt", i),    {16'h0, cnt}, {16'h0, tbl[i].e_cnt});
      chk($sformatf("v%0d_cause", i),  {30'h0, cause}, {30'h0, tbl[i].e_cause});
      chk($sformatf("v%0d_faddr", i),  faddr, tbl[i].e_faddr);
    end

    // back-to-back write then read of the same word
    drive(1, 1, 4'hF, 32'h2000_000C, 32'h0000_0001, 0, 4'h0);
    @(posedge clk); #1;
    drive(1, 0, 4'hF, 32'h2000_000C, 32'h0, 0, 4'h0);
    @(posedge clk); #1;
    chk("b2b_rvalid", {31'h0, rvalid}, 32'h1);
    chk("b2b_rdata",  rdata, 32'h0000_0001);

    // reset while a read response is on the port
    drive(1, 0, 4'hF, 32'h2000_000C, 32'h0, 0, 4'h0);
    @(posedge clk); #1;
    chk("pend_rvalid", {31'h0, rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("mid_rst_cnt",    {16'h0, cnt}, 32'h0);
    chk("mid_rst_cause",  {30'h0, cause}, {30'h0, C_NONE});
    chk("mid_rst_rdata",  rdata, 32'h0);
    drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rvalid", {31'h0, rvalid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
